ex_mem_wb_pipe: RTL and testbench

EX_MEM_WB_PIPE -- requirements
Module: ex_mem_wb_pipe

---
 rtl/ex_mem_wb_pipe_pkg.sv | 12 +
 rtl/mem_req_fsm.sv | 61 ++++++
 rtl/ex_mem_wb_pipe.sv | 131 +++++++++++++
 tb/tb_ex_mem_wb_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_wb_pipe_pkg.sv
// Shared types and widths for the EX/MEM/WB pipeline slice.
// Optional feature macro: LOAD_USE_STALL_EN (used by ex_mem_wb_pipe).
package ex_mem_wb_pipe_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;
endpackage

// File: rtl/mem_req_fsm.sv
// MEM-stage control FSM and data-memory request handshake.
//   state | meaning
//   IDLE  | accepting EX beats, no memory access outstanding
//   BUSY  | dmem request held until ack, EX beats refused
//   DONE  | access finished, MEM result retires to WB, new beat accepted
import ex_mem_wb_pipe_pkg::*;

module mem_req_fsm (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ex_fire,
    input  logic i_ex_memop,
    input  logic i_dmem_ack,
    output logic o_ex_ready,
    output logic o_dmem_req,
    output logic o_ack_fire
);
    mem_state_t r_state;
    logic       r_ready;
    logic       r_req;

    // State and registered handshake outputs move together so they never disagree
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_ex_fire && i_ex_memop) begin
                        r_state <= BUSY;
                        r_ready <= 1'b0;
                        r_req   <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_req   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (i_dmem_ack) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ex_ready = r_ready;
    assign o_dmem_req = r_req;
    // Ack only counts while a request is outstanding
    assign o_ack_fire = (r_state == BUSY) && i_dmem_ack;
endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX->MEM->WB pipeline registers with a blocking data-memory port.
// Optional macro LOAD_USE_STALL_EN adds a hardware load-use stall term.
import ex_mem_wb_pipe_pkg::*;

module ex_mem_wb_pipe (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  ex_RegWrite,
    input  logic                  ex_MemRead,
    input  logic                  ex_MemWrite,
    input  logic [REG_ADDR_W-1:0] ex_rdAddr,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic [REG_ADDR_W-1:0] rs1Addr_id,
    input  logic [REG_ADDR_W-1:0] rs2Addr_id,
    output logic                  ex_ready,
    output logic                  RegWrite_mem,
    output logic [REG_ADDR_W-1:0] rdAddr_mem,
    output logic [XLEN-1:0]       alu_mem,
    output logic                  RegWrite_wb,
    output logic [REG_ADDR_W-1:0] rdAddr_wb,
    output logic [XLEN-1:0]       wb_data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  stall_id
);
    logic                  w_ex_fire;
    logic                  w_ack_fire;
    logic                  w_load_use;

    logic                  r_mem_valid;
    logic                  r_mem_regwrite;
    logic                  r_mem_memread;
    logic                  r_mem_memwrite;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic [XLEN-1:0]       r_mem_alu;
    logic [XLEN-1:0]       r_mem_sdata;
    logic [XLEN-1:0]       r_load_data;

    logic                  r_wb_regwrite;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [XLEN-1:0]       r_wb_data;

    assign w_ex_fire = ex_valid && ex_ready;

    mem_req_fsm u_mem_req_fsm (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ex_fire  (w_ex_fire),
        .i_ex_memop (ex_MemRead || ex_MemWrite),
        .i_dmem_ack (dmem_ack),
        .o_ex_ready (ex_ready),
        .o_dmem_req (dmem_req),
        .o_ack_fire (w_ack_fire)
    );

    // MEM register: loads a new beat whenever the stage is ready, else holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid    <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_alu      <= '0;
            r_mem_sdata    <= '0;
        end else if (ex_ready) begin
            r_mem_valid <= ex_valid;
            if (ex_valid) begin
                r_mem_regwrite <= ex_RegWrite;
                r_mem_memread  <= ex_MemRead;
                r_mem_memwrite <= ex_MemWrite;
                r_mem_rd       <= ex_rdAddr;
                r_mem_alu      <= ex_alu_result;
                r_mem_sdata    <= ex_store_data;
            end
        end
    end

    // Load data is captured on the acknowledging edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_data <= '0;
        end else if (w_ack_fire && r_mem_memread) begin
            r_load_data <= dmem_rdata;
        end
    end

    // WB register: retires MEM when it advances, bubbles while MEM is blocked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_regwrite <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
        end else if (ex_ready) begin
            r_wb_regwrite <= r_mem_valid && r_mem_regwrite && !r_mem_memwrite
                             && (r_mem_rd != '0);
            r_wb_rd       <= r_mem_rd;
            r_wb_data     <= r_mem_memread ? r_load_data : r_mem_alu;
        end else begin
            r_wb_regwrite <= 1'b0;
        end
    end

`ifdef LOAD_USE_STALL_EN
    assign w_load_use = ex_valid && ex_MemRead && (ex_rdAddr != '0)
                        && ((ex_rdAddr == rs1Addr_id) || (ex_rdAddr == rs2Addr_id));
`else
    // Hazards are scheduled away by software; source addresses are unused
    assign w_load_use = 1'b0;
    logic w_unused_rs;
    assign w_unused_rs = ^{rs1Addr_id, rs2Addr_id};
`endif

    assign RegWrite_mem = r_mem_valid && r_mem_regwrite && (r_mem_rd != '0);
    assign rdAddr_mem   = r_mem_rd;
    assign alu_mem      = r_mem_alu;
    assign RegWrite_wb  = r_wb_regwrite;
    assign rdAddr_wb    = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign dmem_we      = dmem_req && r_mem_memwrite;
    assign dmem_addr    = r_mem_alu;
    assign dmem_wdata   = r_mem_sdata;
    // Gated by reset so the combinational hazard term cannot leak out during reset
    assign stall_id     = rst_n && (!ex_ready || w_load_use);
endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Self-checking bench for ex_mem_wb_pipe: directed stimulus, WB scoreboard.
module tb_ex_mem_wb_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_RegWrite = 1'b0, ex_MemRead = 1'b0, ex_MemWrite = 1'b0;
    logic [3:0]  ex_rdAddr = '0;
    logic [31:0] ex_alu_result = '0, ex_store_data = '0;
    logic [3:0]  rs1Addr_id = '0, rs2Addr_id = '0;
    logic        ex_ready, RegWrite_mem, RegWrite_wb;
    logic [3:0]  rdAddr_mem, rdAddr_wb;
    logic [31:0] alu_mem, wb_data;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic        stall_id;

`ifdef LOAD_USE_STALL_EN
    localparam logic LU_EN = 1'b1;
`else
    localparam logic LU_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [35:0] sb[$];   // {rd, data} of expected register-file writes

    ex_mem_wb_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_rdAddr(ex_rdAddr), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
        .ex_ready(ex_ready), .RegWrite_mem(RegWrite_mem), .rdAddr_mem(rdAddr_mem),
        .alu_mem(alu_mem), .RegWrite_wb(RegWrite_wb), .rdAddr_wb(rdAddr_wb),
        .wb_data(wb_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall_id(stall_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic rw, input logic mr, input logic mw, input logic [3:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd);
        ex_valid = 1'b1; ex_RegWrite = rw; ex_MemRead = mr; ex_MemWrite = mw;
        ex_rdAddr = rd; ex_alu_result = alu; ex_store_data = sd;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_RegWrite = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0;
    endtask

    // Monitor: every register-file write must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && RegWrite_wb) begin
            if (sb.size() == 0) begin
                check("wb_unexpected_write", {28'd0, rdAddr_wb}, 32'hFFFF_FFFF);
            end else begin
                logic [35:0] e;
                e = sb.pop_front();
                check("wb_rd", {28'd0, rdAddr_wb}, {28'd0, e[35:32]});
                check("wb_data", wb_data, e[31:0]);
            end
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_RegWrite_mem", {31'd0, RegWrite_mem}, 32'd0);
        check("rst_RegWrite_wb", {31'd0, RegWrite_wb}, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall_id", {31'd0, stall_id}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, ex_ready}, 32'd1);

        // ALU op rd=5 -> MEM next cycle, WB the cycle after
        issue(1, 0, 0, 4'd5, 32'h1234, 32'h0);
        sb.push_back({4'd5, 32'h1234});
        @(negedge clk); idle();
        check("alu_RegWrite_mem", {31'd0, RegWrite_mem}, 32'd1);
        check("alu_rdAddr_mem", {28'd0, rdAddr_mem}, 32'd5);
        check("alu_alu_mem", alu_mem, 32'h1234);
        @(negedge clk);
        check("alu_RegWrite_wb", {31'd0, RegWrite_wb}, 32'd1);
        @(negedge clk);
        check("alu_wb_pulse_once", {31'd0, RegWrite_wb}, 32'd0);

        // rd=0 flows without any write enable
        issue(1, 0, 0, 4'd0, 32'h9999, 32'h0);
        @(negedge clk); idle();
        check("rd0_RegWrite_mem", {31'd0, RegWrite_mem}, 32'd0);
        @(negedge clk);
        check("rd0_RegWrite_wb", {31'd0, RegWrite_wb}, 32'd0);

        // Back-to-back ALU ops
        issue(1, 0, 0, 4'd1, 32'h11, 32'h0); sb.push_back({4'd1, 32'h11});
        @(negedge clk);
        issue(1, 0, 0, 4'd2, 32'h22, 32'h0); sb.push_back({4'd2, 32'h22});
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk);

        // Ack in IDLE is ignored
        dmem_ack = 1'b1;
        @(negedge clk); dmem_ack = 1'b0;
        check("idle_ack_req", {31'd0, dmem_req}, 32'd0);
        check("idle_ack_ready", {31'd0, ex_ready}, 32'd1);

        // Load rd=3 @0x100, ack after 3 cycles
        issue(1, 1, 0, 4'd3, 32'h100, 32'h0);
        sb.push_back({4'd3, 32'hDEAD_BEEF});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            check("ld_req", {31'd0, dmem_req}, 32'd1);
            check("ld_addr", dmem_addr, 32'h100);
            check("ld_we", {31'd0, dmem_we}, 32'd0);
            check("ld_ready", {31'd0, ex_ready}, 32'd0);
            check("ld_stall", {31'd0, stall_id}, 32'd1);
            check("ld_wb_bubble", {31'd0, RegWrite_wb}, 32'd0);
            if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
        end
        @(negedge clk); dmem_ack = 1'b0; dmem_rdata = '0;
        check("ld_done_req", {31'd0, dmem_req}, 32'd0);
        check("ld_done_ready", {31'd0, ex_ready}, 32'd1);
        dmem_ack = 1'b1;   // ack in DONE must be ignored
        @(negedge clk); dmem_ack = 1'b0;
        check("ld_rdAddr_wb", {28'd0, rdAddr_wb}, 32'd3);
        check("done_ack_req", {31'd0, dmem_req}, 32'd0);

        // Store @0x40 data 0x55, RegWrite asserted upstream but must not write back
        issue(1, 0, 1, 4'd8, 32'h40, 32'h55);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle();
            check("st_req", {31'd0, dmem_req}, 32'd1);
            check("st_we", {31'd0, dmem_we}, 32'd1);
            check("st_addr", dmem_addr, 32'h40);
            check("st_wdata", dmem_wdata, 32'h55);
            if (i == 1) dmem_ack = 1'b1;
        end
        @(negedge clk); dmem_ack = 1'b0;
        check("st_done_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        @(negedge clk);

        // Load with ALU beat held during BUSY, consumed in DONE
        issue(1, 1, 0, 4'd4, 32'h8, 32'h0);
        sb.push_back({4'd4, 32'hCAFE_F00D});
        sb.push_back({4'd6, 32'h66});
        @(negedge clk);
        issue(1, 0, 0, 4'd6, 32'h66, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk); dmem_ack = 1'b0; dmem_rdata = '0;
        check("held_beat_ready", {31'd0, ex_ready}, 32'd1);
        @(negedge clk); idle();
        check("held_beat_in_mem", {28'd0, rdAddr_mem}, 32'd6);
        @(negedge clk);
        @(negedge clk);

        // Load-use hazard: EX load rd=7 while ID reads r7
        rs2Addr_id = 4'd7;
        issue(1, 1, 0, 4'd7, 32'h20, 32'h0);
        #1;
        check("load_use_stall", {31'd0, stall_id}, {31'd0, LU_EN});
        sb.push_back({4'd7, 32'h0000_0777});
        @(negedge clk); idle(); rs2Addr_id = '0;
        dmem_ack = 1'b1; dmem_rdata = 32'h0000_0777;
        @(negedge clk); dmem_ack = 1'b0; dmem_rdata = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset mid-BUSY drops request immediately, discards the load
        issue(1, 1, 0, 4'd9, 32'h200, 32'h0);
        @(negedge clk); idle();
        check("busy_before_rst", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy_req", {31'd0, dmem_req}, 32'd0);
        check("rst_busy_ready", {31'd0, ex_ready}, 32'd1);
        check("rst_busy_RegWrite_mem", {31'd0, RegWrite_mem}, 32'd0);
        check("rst_busy_stall", {31'd0, stall_id}, 32'd0);
        #1;
        issue(1, 0, 0, 4'd10, 32'hA0A0, 32'h0);
        sb.push_back({4'd10, 32'hA0A0});
        #1 rst_n = 1'b1;
        @(negedge clk); idle();
        check("post_rst_first_beat", {31'd0, RegWrite_mem}, 32'd1);
        check("post_rst_rdAddr_mem", {28'd0, rdAddr_mem}, 32'd10);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
